pc_gen: RTL and testbench

Parametrised program-counter generator for the RV32I pipelined core, in the IF stage. It replaces the plain enable-gated PC register, driving instruction-memory fetch requests over a valid/ready handshake. It also provides:
- a boot delay after reset;
- trap and branch/jump redirects with priority, and buffering of a redirect that arrives while a fetch request is outstanding;
- misaligned-target detection;
- a debug halt state.

---
 rtl/pc_gen_pkg.sv | 34 +++
 rtl/pc_gen_if.sv | 31 +++
 rtl/pc_redirect_buf.sv | 50 +++++
 rtl/pc_gen.sv | 171 +++++++++++++++++
 tb/tb_pc_gen.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_pkg
//  Description : Shared types and constants for the IF-stage PC generator.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_gen_pkg;

   // Top-level control states of the PC generator.
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } pc_state_e;

   // Size of one RV32I instruction in bytes.
   localparam int INSN_BYTES = 4;

   // Source chosen for the next PC value in a given cycle.
   typedef enum logic [2:0] {
      NONE  = 3'd0,
      SEQ   = 3'd1,
      REDIR = 3'd2,
      TRAP  = 3'd3,
      PEND  = 3'd4
   } redir_src_e;

   // Instruction targets must be word aligned.
   function automatic logic is_word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_if
//  Description : Instruction-memory fetch request channel (valid/ready).
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            req_valid_o;
   logic            req_ready_i;
   logic [XLEN-1:0] req_addr_o;
   logic [XLEN-1:0] pc_plus4_o;

   // PC generator side: issues fetch requests.
   modport master (
      output req_valid_o,
      output req_addr_o,
      output pc_plus4_o,
      input  req_ready_i
   );

   // Instruction memory side: accepts fetch requests.
   modport slave (
      input  req_valid_o,
      input  req_addr_o,
      input  pc_plus4_o,
      output req_ready_i
   );
endinterface
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pc_redirect_buf
//  Description : Single-entry slot holding a redirect target that arrived
//                while a fetch request was stuck waiting for imem.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_redirect_buf #(
   parameter int XLEN = 32
) (
   input  wire logic            clk,
   input  wire logic            reset,
   input  wire logic            wr_en_i,
   input  wire logic [XLEN-1:0] wr_target_i,
   input  wire logic            clr_i,
   output logic                 valid_o,
   output logic [XLEN-1:0]      target_o
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] target_q, target_d;

   // A newer redirect always overwrites older content; write beats clear.
   always_comb begin
      valid_d  = valid_q;
      target_d = target_q;
      if (wr_en_i) begin
         valid_d  = 1'b1;
         target_d = wr_target_i;
      end else if (clr_i) begin
         valid_d  = 1'b0;
      end
   end

   // Slot storage with asynchronous reset to empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q  <= 1'b0;
         target_q <= '0;
      end else begin
         valid_q  <= valid_d;
         target_q <= target_d;
      end
   end

   assign valid_o  = valid_q;
   assign target_o = target_q;

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : IF-stage program-counter generator. Boots after reset,
//                issues fetch requests over valid/ready, applies trap and
//                branch redirects (buffering them while a request is stuck),
//                rejects misaligned redirect targets and supports debug halt.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              BOOT_CYCLES  = 2
) (
   input  wire logic            clk,
   input  wire logic            reset,
   input  wire logic            stall_i,
   input  wire logic            halt_i,
   input  wire logic            redir_valid_i,
   input  wire logic [XLEN-1:0] redir_target_i,
   input  wire logic            trap_valid_i,
   input  wire logic [XLEN-1:0] trap_vector_i,
   pc_gen_if.master             imem,
   output logic                 misalign_o,
   output logic [XLEN-1:0]      misalign_addr_o,
   output logic                 halted_o
);

   localparam logic [3:0]      BOOT_INIT = 4'(BOOT_CYCLES);
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INSN_BYTES);

   pc_state_e       state_q, state_d;
   logic [3:0]      boot_cnt_q, boot_cnt_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            hold_q, hold_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

   logic            req_valid;
   logic            locked;
   logic            handshake;
   logic            accept;
   logic            redir_ok;
   logic            redir_bad;
   logic [XLEN-1:0] trap_tgt;
   logic [XLEN-1:0] in_tgt;
   redir_src_e      src;
   logic            pend_wr;
   logic            pend_clr;
   logic            pend_valid;
   logic [XLEN-1:0] pend_tgt;

   // The low two bits of mtvec select the vectoring mode, not the address.
   logic            unused_trap_lsb;
   assign unused_trap_lsb = ^trap_vector_i[1:0];

   // Request qualification and redirect classification.
   always_comb begin
      req_valid = (state_q == FETCH) && (hold_q || !stall_i);
      locked    = req_valid && !imem.req_ready_i;
      handshake = req_valid && imem.req_ready_i;
      accept    = (state_q != BOOT);
      trap_tgt  = {trap_vector_i[XLEN-1:2], 2'b00};
      redir_ok  = redir_valid_i && is_word_aligned(redir_target_i[1:0]);
      redir_bad = redir_valid_i && !is_word_aligned(redir_target_i[1:0]);
      in_tgt    = trap_valid_i ? trap_tgt : redir_target_i;
   end

   // Next-PC source selection, pending-slot control, misalign reporting.
   always_comb begin
      src             = NONE;
      pc_d            = pc_q;
      pend_wr         = 1'b0;
      pend_clr        = 1'b0;
      hold_d          = locked;
      misalign_d      = accept && redir_bad;
      misalign_addr_d = (accept && redir_bad) ? redir_target_i : '0;

      if (accept) begin
         if (trap_valid_i) begin
            src = TRAP;
         end else if (redir_ok) begin
            src = REDIR;
         end else if (handshake) begin
            src = pend_valid ? PEND : SEQ;
         end
      end

      if (locked) begin
         // The request on the bus must not change; park the redirect.
         pend_wr = (src == TRAP) || (src == REDIR);
      end else begin
         pend_clr = (src != NONE);
         case (src)
            TRAP:    pc_d = in_tgt;
            REDIR:   pc_d = in_tgt;
            PEND:    pc_d = pend_tgt;
            SEQ:     pc_d = pc_q + PC_STEP;
            default: pc_d = pc_q;
         endcase
      end
   end

   // Control FSM: boot countdown, fetch, debug halt.
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      case (state_q)
         BOOT: begin
            boot_cnt_d = boot_cnt_q - 4'd1;
            if (boot_cnt_q <= 4'd1) begin
               boot_cnt_d = 4'd0;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            if (halt_i && !locked) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (!halt_i || trap_valid_i) begin
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= BOOT;
         boot_cnt_q      <= BOOT_INIT;
         pc_q            <= RESET_VECTOR;
         hold_q          <= 1'b0;
         misalign_q      <= 1'b0;
         misalign_addr_q <= '0;
      end else begin
         state_q         <= state_d;
         boot_cnt_q      <= boot_cnt_d;
         pc_q            <= pc_d;
         hold_q          <= hold_d;
         misalign_q      <= misalign_d;
         misalign_addr_q <= misalign_addr_d;
      end
   end

   pc_redirect_buf #(
      .XLEN (XLEN)
   ) u_redirect_buf (
      .clk         (clk),
      .reset       (reset),
      .wr_en_i     (pend_wr),
      .wr_target_i (in_tgt),
      .clr_i       (pend_clr),
      .valid_o     (pend_valid),
      .target_o    (pend_tgt)
   );

   assign imem.req_valid_o = req_valid;
   assign imem.req_addr_o  = pc_q;
   assign imem.pc_plus4_o  = pc_q + PC_STEP;
   assign misalign_o       = misalign_q;
   assign misalign_addr_o  = misalign_addr_q;
   assign halted_o         = (state_q == HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Directed vector bench for pc_gen (RESET_VECTOR=0x100,
//                BOOT_CYCLES=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i;
   logic        halt_i;
   logic        redir_valid_i;
   logic [31:0] redir_target_i;
   logic        trap_valid_i;
   logic [31:0] trap_vector_i;
   logic        misalign_o;
   logic [31:0] misalign_addr_o;
   logic        halted_o;

   int checks = 0;
   int errors = 0;

   pc_gen_if #(.XLEN(32)) imem ();

   pc_gen #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_0100),
      .BOOT_CYCLES  (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall_i         (stall_i),
      .halt_i          (halt_i),
      .redir_valid_i   (redir_valid_i),
      .redir_target_i  (redir_target_i),
      .trap_valid_i    (trap_valid_i),
      .trap_vector_i   (trap_vector_i),
      .imem            (imem.master),
      .misalign_o      (misalign_o),
      .misalign_addr_o (misalign_addr_o),
      .halted_o        (halted_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        rdy;
      logic        rv;
      logic [31:0] rt;
      logic        tv;
      logic [31:0] tt;
      logic        hl;
      logic        ev;
      logic [31:0] ea;
      logic        em;
      logic [31:0] ema;
      logic        eh;
   } vec_t;

   localparam int NV = 30;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic st, input logic rdy, input logic rv,
                               input logic [31:0] rt, input logic tv,
                               input logic [31:0] tt, input logic hl,
                               input logic ev, input logic [31:0] ea,
                               input logic em, input logic [31:0] ema,
                               input logic eh);
      vec_t v;
      v.st = st; v.rdy = rdy; v.rv = rv; v.rt = rt; v.tv = tv; v.tt = tt;
      v.hl = hl; v.ev = ev; v.ea = ea; v.em = em; v.ema = ema; v.eh = eh;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      stall_i          = v.st;
      imem.req_ready_i = v.rdy;
      redir_valid_i    = v.rv;
      redir_target_i   = v.rt;
      trap_valid_i     = v.tv;
      trap_vector_i    = v.tt;
      halt_i           = v.hl;
   endtask

   initial begin
      //                 st rdy rv rt            tv tt            hl | ev ea            em ema           eh
      tbl[0]  = mk(0, 1, 1, 32'h0000_0700, 1, 32'h0000_0900, 0, 0, 32'h0000_0100, 0, 32'h0, 0);
      tbl[1]  = mk(0, 1, 1, 32'h0000_0704, 0, 32'h0,        0, 0, 32'h0000_0100, 0, 32'h0, 0);
      tbl[2]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0100, 0, 32'h0, 0);
      tbl[3]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0104, 0, 32'h0, 0);
      tbl[4]  = mk(0, 1, 1, 32'h0000_0200, 0, 32'h0,        0, 1, 32'h0000_0108, 0, 32'h0, 0);
      tbl[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0200, 0, 32'h0, 0);
      tbl[6]  = mk(0, 0, 1, 32'h0000_0400, 0, 32'h0,        0, 1, 32'h0000_0200, 0, 32'h0, 0);
      tbl[7]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0200, 0, 32'h0, 0);
      tbl[8]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0200, 0, 32'h0, 0);
      tbl[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0400, 0, 32'h0, 0);
      tbl[10] = mk(0, 0, 1, 32'h0000_0500, 1, 32'h0000_0803, 0, 1, 32'h0000_0400, 0, 32'h0, 0);
      tbl[11] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0400, 0, 32'h0, 0);
      tbl[12] = mk(0, 1, 1, 32'h0000_0302, 0, 32'h0,        0, 1, 32'h0000_0800, 0, 32'h0, 0);
      tbl[13] = mk(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,        0, 1, 32'h0000_0804, 1, 32'h0000_0302, 0);
      tbl[14] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
      tbl[15] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0000, 0, 32'h0, 0);
      tbl[16] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0000, 0, 32'h0, 0);
      tbl[17] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0000, 0, 32'h0, 0);
      tbl[18] = mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0000, 0, 32'h0, 0);
      tbl[19] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0000, 0, 32'h0, 0);
      tbl[20] = mk(0, 1, 1, 32'h0000_0600, 0, 32'h0,        1, 0, 32'h0000_0004, 0, 32'h0, 1);
      tbl[21] = mk(0, 1, 0, 32'h0,        1, 32'h0000_0903, 1, 0, 32'h0000_0600, 0, 32'h0, 1);
      tbl[22] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0900, 0, 32'h0, 0);
      tbl[23] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0904, 0, 32'h0, 0);
      tbl[24] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0908, 0, 32'h0, 0);
      tbl[25] = mk(0, 0, 1, 32'h0000_0A00, 0, 32'h0,        0, 1, 32'h0000_0908, 0, 32'h0, 0);
      tbl[26] = mk(0, 0, 1, 32'h0000_0A06, 0, 32'h0,        0, 1, 32'h0000_0908, 0, 32'h0, 0);
      tbl[27] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0908, 1, 32'h0000_0A06, 0);
      tbl[28] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0A00, 0, 32'h0, 0);
      tbl[29] = mk(0, 0, 1, 32'h0000_0B00, 0, 32'h0,        0, 1, 32'h0000_0A00, 0, 32'h0, 0);

      reset = 1'b1;
      drive(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_valid",   {31'd0, imem.req_valid_o}, 32'd0);
      chk("rst_addr",    imem.req_addr_o, 32'h0000_0100);
      chk("rst_plus4",   imem.pc_plus4_o, 32'h0000_0104);
      chk("rst_mis",     {31'd0, misalign_o}, 32'd0);
      chk("rst_misaddr", misalign_addr_o, 32'd0);
      chk("rst_halted",  {31'd0, halted_o}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i]);
         #1;
         chk($sformatf("v%0d_valid", i), {31'd0, imem.req_valid_o}, {31'd0, tbl[i].ev});
         chk($sformatf("v%0d_addr", i), imem.req_addr_o, tbl[i].ea);
         chk($sformatf("v%0d_plus4", i), imem.pc_plus4_o, tbl[i].ea + 32'd4);
         chk($sformatf("v%0d_mis", i), {31'd0, misalign_o}, {31'd0, tbl[i].em});
         if (tbl[i].em)
            chk($sformatf("v%0d_misaddr", i), misalign_addr_o, tbl[i].ema);
         chk($sformatf("v%0d_halted", i), {31'd0, halted_o}, {31'd0, tbl[i].eh});
         @(posedge clk);
         @(negedge clk);
      end

      // Reset between edges with a redirect parked in the pending slot.
      drive(mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0));
      #2;
      reset = 1'b1;
      #1;
      chk("abort_valid", {31'd0, imem.req_valid_o}, 32'd0);
      chk("abort_addr",  imem.req_addr_o, 32'h0000_0100);
      chk("abort_plus4", imem.pc_plus4_o, 32'h0000_0104);
      @(negedge clk);
      reset = 1'b0;
      imem.req_ready_i = 1'b1;
      #1;
      chk("reboot_c0_valid", {31'd0, imem.req_valid_o}, 32'd0);
      @(negedge clk);
      #1;
      chk("reboot_c1_valid", {31'd0, imem.req_valid_o}, 32'd0);
      @(negedge clk);
      #1;
      chk("reboot_c2_valid", {31'd0, imem.req_valid_o}, 32'd1);
      chk("reboot_c2_addr",  imem.req_addr_o, 32'h0000_0100);
      @(negedge clk);
      #1;
      chk("reboot_c3_addr",  imem.req_addr_o, 32'h0000_0104);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
